// File: rtl/store_commit_writer.sv
// Drains committed ROB stores from a small FIFO as little-endian byte writes on the RAM bus.
// Optional IO backpressure (IO_WAIT state) is enabled by defining STORE_IO_BACKPRESSURE_EN.
module store_commit_writer #(
    parameter int         QUEUE_DEPTH_WIDTH = 2,
    parameter logic [1:0] IO_ADDR_HI        = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_valid,
    input  logic [1:0]  rob_store_type,
    input  logic [31:0] rob_addr,
    input  logic [31:0] rob_value,
    output logic        mem_busy,
    input  logic        io_buffer_full,
    input  logic        ram_grant,
    output logic        ram_req,
    output logic [31:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_wr,
    output logic        idle_out
);
    localparam int QW    = QUEUE_DEPTH_WIDTH;
    localparam int DEPTH = 2 ** QW;
    localparam int CW    = QW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE
`ifdef STORE_IO_BACKPRESSURE_EN
        , S_IO_WAIT
`endif
    } state_t;

    logic [1:0]    r_type [DEPTH];
    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_val  [DEPTH];
    logic [QW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;
    logic [1:0]    r_k;
    state_t        r_state, w_next;

    logic [1:0]  w_htype;
    logic [31:0] w_haddr, w_hval, w_shift;
    logic        w_last, w_illegal, w_active, w_io_stall, w_go, w_emit, w_pop, w_push;
    logic [CW:0] w_sum;

    assign w_htype   = r_type[r_head];
    assign w_haddr   = r_addr[r_head];
    assign w_hval    = r_val[r_head];
    assign w_shift   = w_hval >> {r_k, 3'b000};
    assign w_illegal = (w_htype == 2'b11);
    assign w_last    = (w_htype == 2'b00) ? (r_k == 2'd0) :
                       (w_htype == 2'b01) ? (r_k == 2'd1) : (r_k == 2'd3);

`ifdef STORE_IO_BACKPRESSURE_EN
    assign w_io_stall = (w_haddr[17:16] == IO_ADDR_HI) && io_buffer_full;
`else
    logic w_unused_io;
    assign w_unused_io = io_buffer_full ^ (|IO_ADDR_HI);
    assign w_io_stall  = 1'b0;
`endif

    // IDLE with a visible head behaves like WRITE so the first byte leaves one edge after the push.
    assign w_active = (r_state == S_WRITE) || (r_state == S_IDLE && r_count != '0);
    assign w_go     = rdy_in && w_active && ram_grant && !w_io_stall;
    assign w_emit   = w_go && !w_illegal;
    assign w_pop    = w_go && (w_illegal || w_last);
    assign w_push   = rdy_in && rob_valid && (r_count != DEPTH_C);

    assign w_sum    = {1'b0, r_count} + {{CW{1'b0}}, rob_valid};
    assign mem_busy = (w_sum >= DEPTH_W);
    assign ram_req  = (r_count != '0);
    assign idle_out = (r_count == '0) && (r_state == S_IDLE) && !ram_wr;

    always_comb begin
        w_next = r_state;
        if (rdy_in) begin
            case (r_state)
                S_IDLE, S_WRITE: begin
                    if (w_active) begin
`ifdef STORE_IO_BACKPRESSURE_EN
                        if (w_io_stall)
                            w_next = S_IO_WAIT;
                        else
`endif
                        if (w_pop)
                            w_next = (r_count != CW'(1) || w_push) ? S_WRITE : S_IDLE;
                        else
                            w_next = S_WRITE;
                    end
                end
`ifdef STORE_IO_BACKPRESSURE_EN
                S_IO_WAIT: if (!io_buffer_full) w_next = S_WRITE;
`endif
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Entry storage needs no reset; validity is carried by head/tail/count.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_type[r_tail] <= rob_store_type;
            r_addr[r_tail] <= rob_addr;
            r_val[r_tail]  <= rob_value;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_k      <= '0;
            r_state  <= S_IDLE;
            ram_wr   <= 1'b0;
            ram_a    <= '0;
            ram_dout <= '0;
        end else if (rdy_in) begin
            r_state <= w_next;
            ram_wr  <= w_emit;
            if (w_emit) begin
                ram_a    <= w_haddr + {30'b0, r_k};
                ram_dout <= w_shift[7:0];
                r_k      <= r_k + 2'd1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
                r_k    <= '0;
            end
            if (w_push)
                r_tail <= r_tail + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end else begin
            ram_wr <= 1'b0;
        end
    end
endmodule

// File: tb/tb_store_commit_writer.sv
// Randomized + directed bench for store_commit_writer against a queue-of-stores reference model.
module tb_store_commit_writer;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_valid, io_buffer_full, ram_grant;
    logic [1:0]  rob_store_type;
    logic [31:0] rob_addr, rob_value;
    logic        mem_busy, ram_req, ram_wr, idle_out;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;

    store_commit_writer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_valid(rob_valid),
        .rob_store_type(rob_store_type), .rob_addr(rob_addr), .rob_value(rob_value),
        .mem_busy(mem_busy), .io_buffer_full(io_buffer_full), .ram_grant(ram_grant),
        .ram_req(ram_req), .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr),
        .idle_out(idle_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] a;
        logic [31:0] v;
        int          n;
        int          idx;
    } st_t;

    st_t stq[$];
    int  n_chk = 0, n_err = 0, nwr = 0;
    bit  chk_comb = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs, take the edge, score any byte write.
    task automatic step(input logic v, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                        input logic g, input logic r);
        st_t s;
        rob_valid = v; rob_store_type = t; rob_addr = a; rob_value = d; ram_grant = g; rdy_in = r;
        #1;
        if (chk_comb) begin
            chk("mem_busy", 32'(mem_busy), 32'((stq.size() + int'(v)) >= 4));
            chk("ram_req",  32'(ram_req),  32'(stq.size() != 0));
            chk("idle_out", 32'(idle_out), 32'(stq.size() == 0 && !ram_wr));
        end
        @(posedge clk_in);
        if (r && v && t != 2'b11) begin
            s.a = a; s.v = d; s.idx = 0;
            s.n = (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
            stq.push_back(s);
        end
        #1;
        if (ram_wr) begin
            nwr++;
            if (stq.size() == 0) chk("spurious_wr", 32'd1, 32'd0);
            else begin
                s = stq[0];
                chk("wr_addr", ram_a, s.a + 32'(s.idx));
                chk("wr_data", {24'b0, ram_dout}, (s.v >> (8 * s.idx)) & 32'hFF);
                s.idx++;
                if (s.idx == s.n) stq.delete(0);
                else stq[0] = s;
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && stq.size() != 0; i++) step(0, 0, 0, 0, 1, 1);
        chk(tag, 32'(stq.size()), 32'd0);
        step(0, 0, 0, 0, 1, 1);
    endtask

    initial begin
        int w0;
        rst_in = 1; rdy_in = 1; rob_valid = 0; rob_store_type = 0; rob_addr = 0; rob_value = 0;
        io_buffer_full = 0; ram_grant = 0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_wr", 32'(ram_wr), 0);
        chk("rst_a", ram_a, 0);
        chk("rst_dout", {24'b0, ram_dout}, 0);
        chk("rst_idle", 32'(idle_out), 1);
        chk("rst_req", 32'(ram_req), 0);
        chk("rst_busy", 32'(mem_busy), 0);
        rst_in = 0;
        chk_comb = 1;

        // word store: four consecutive bytes, little-endian
        step(1, 2'b10, 32'h1000, 32'hAABBCCDD, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 1);
            chk("word_lat", 32'(ram_wr), 1);
        end
        step(0, 0, 0, 0, 1, 1);
        chk("word_idle", 32'(idle_out), 1);

        // half store across the 32-bit address wrap
        step(1, 2'b01, 32'hFFFF_FFFF, 32'h0000_1234, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        chk("wrap_a", ram_a, 32'h0);
        step(0, 0, 0, 0, 1, 1);

        // four byte pushes without grant, then release
        w0 = nwr;
        for (int i = 0; i < 4; i++) step(1, 2'b00, 32'h2000 + 32'(i), 32'(8'h50 + i), 0, 1);
        chk("bp_busy", 32'(mem_busy), 1);
        chk("bp_nowr", 32'(nwr - w0), 0);
        drain("bp_drain");
        chk("bp_count", 32'(nwr - w0), 4);

        // reset after byte 1 of a word has gone out
        step(1, 2'b10, 32'h4000, 32'h1122_3344, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        #2 rst_in = 1;
        #1;
        chk("rstmid_wr", 32'(ram_wr), 0);
        chk("rstmid_idle", 32'(idle_out), 1);
        chk("rstmid_busy", 32'(mem_busy), 0);
        chk("rstmid_req", 32'(ram_req), 0);
        stq.delete();
        @(posedge clk_in);
        #1 rst_in = 0;

        // illegal entry drains silently ahead of a word
        chk_comb = 0;
        step(1, 2'b11, 32'h5000, 32'hDEAD_BEEF, 1, 1);
        step(1, 2'b10, 32'h6000, 32'hCAFE_BABE, 1, 1);
        chk("ill_nowr", 32'(ram_wr), 0);
        step(0, 0, 0, 0, 1, 1);
        chk("ill_first", 32'(ram_wr), 1);
        drain("ill_drain");
        chk_comb = 1;

`ifdef STORE_IO_BACKPRESSURE_EN
        io_buffer_full = 1;
        step(1, 2'b00, 32'h0003_0000, 32'h0000_005A, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 1);
            chk("io_nowr", 32'(ram_wr), 0);
        end
        io_buffer_full = 0;
        step(0, 0, 0, 0, 1, 1);
        chk("io_edge1", 32'(ram_wr), 0);
        step(0, 0, 0, 0, 1, 1);
        chk("io_edge2", 32'(ram_wr), 1);
        chk("io_addr", ram_a, 32'h0003_0000);
        drain("io_drain");
`else
        io_buffer_full = 1;
        step(1, 2'b00, 32'h0003_0000, 32'h0000_005A, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        chk("io_ignored", 32'(ram_wr), 1);
        io_buffer_full = 0;
        drain("io_drain");
`endif

        // randomized traffic with grant and rdy gaps
        for (int i = 0; i < 400; i++) begin
            logic v;
            v = (stq.size() < 4) && ($urandom_range(0, 1) == 1);
            step(v, 2'($urandom_range(0, 2)), $urandom, $urandom,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0));
        end
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/store_commit_writer.md
Name: store_commit_writer

Overview:
- Memory-side responder for committed stores issued by the reorder buffer.
- Accepts (store_type, addr, value) commits into a small FIFO and drives `mem_busy` back to the ROB.
- Serialises each store into little-endian byte writes on the 8-bit RAM bus, under an external bus grant.
- Committed stores are architectural: no flush input exists, and queued stores always drain.

Parameters:
- QUEUE_DEPTH_WIDTH, 2, log2 of FIFO depth; DEPTH = 2**QUEUE_DEPTH_WIDTH = 4.
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks memory-mapped IO.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global enable; low = freeze all state.
- rob_valid  in  1  store commit strobe (ROB rob2mem_ready).
- rob_store_type  in  2  00 byte, 01 half, 10 word, 11 illegal.
- rob_addr  in  32  byte address.
- rob_value  in  32  store data.
- mem_busy  out  1  combinational: (count + rob_valid) >= DEPTH.
- io_buffer_full  in  1  IO device cannot accept a byte.
- ram_grant  in  1  arbiter grants RAM bus to this block this cycle.
- ram_req  out  1  combinational: count != 0.
- ram_a  out  32  RAM byte address (registered).
- ram_dout  out  8  RAM write data (registered).
- ram_wr  out  1  RAM write enable (registered, 1-cycle pulse per byte).
- idle_out  out  1  combinational: count == 0 && state == IDLE && !ram_wr.

Behaviour:
- Reset (async), all outputs and state:
  - head, tail, count = 0; byte index k = 0; state = IDLE.
  - ram_wr = 0, ram_a = 0, ram_dout = 0.
  - A partially written store at reset is discarded.
- rdy_in low: no state change; ram_wr forced to 0 at the next edge; rob_valid ignored.
- Push:
  - On an edge with rdy_in && rob_valid, the entry is written at tail; tail wraps mod DEPTH.
  - Type 11 entries are pushed but popped with zero bytes written.
- Backpressure:
  - mem_busy includes the in-flight rob_valid. This guarantees a commit issued one cycle after the ROB samples mem_busy=0 always fits.
  - A push with count == DEPTH is a protocol violation; the entry is dropped and count saturates.
- Byte count: n = 1 / 2 / 4 for types 00 / 01 / 10.
  - Byte k goes to address addr+k with data value[8k+7:8k]; 32-bit addition wraps.
- FSM:
  - IDLE → WRITE when count != 0 (head visible the edge after push).
  - WRITE, on an edge with rdy_in && ram_grant && !io_stall:
    - ram_wr <= 1, ram_a <= head.addr + k, ram_dout <= byte k, k <= k+1.
    - After byte n-1: pop head, k <= 0. Go to WRITE if count-1 != 0 (or a push occurs this edge), else IDLE.
  - WRITE with !ram_grant: ram_wr <= 0; hold state.
  - io_stall = (head.addr[17:16] == IO_ADDR_HI) && io_buffer_full.
    - WRITE with io_stall → IO_WAIT, ram_wr <= 0.
  - IO_WAIT → WRITE when !io_buffer_full. No byte is emitted on the transition edge, so IO bytes are never written while the IO device is full.
- Latency: word store pushed at edge E0 → ram_wr high after E1, E2, E3, E4 (grant held) → pop at E4.
- Simultaneous push and pop: count unchanged; head and tail advance independently.
- ram_wr is never high for two consecutive bytes unless ram_grant stayed high across both edges.

Optional Feature:
- Macro STORE_IO_BACKPRESSURE_EN.
- Defined: io_stall and the IO_WAIT state behave as specified above.
- Undefined: IO_WAIT is absent, io_buffer_full is ignored (left unconnected internally), and IO addresses are written like RAM.

Test Plan:
- Reset mid-word-write (after byte 1 emitted) → next cycle: ram_wr=0, count=0, idle_out=1, mem_busy=0.
- Word push addr=0x1000, value=0xAABBCCDD, ram_grant=1 → writes (0x1000,DD), (0x1001,CC), (0x1002,BB), (0x1003,AA) on 4 consecutive cycles; then idle_out=1.
- Half push addr=0xFFFFFFFF, value=0x1234 → writes (0xFFFFFFFF,34), (0x00000000,12), confirming address wrap.
- 4 back-to-back byte pushes with ram_grant=0 → mem_busy=1 on the cycle of the 4th rob_valid; grant=1 → 4 single writes in FIFO order; mem_busy falls after the first pop.
- With the macro defined: byte store to 0x30000 while io_buffer_full=1 for 5 cycles → no ram_wr; first write to 0x30000 occurs 2 edges after io_buffer_full falls.
- rob_store_type=11 push followed by word push → the illegal entry produces no ram_wr; the word's first byte appears after the illegal entry pops.
